// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: accepts one FP op, runs the start/done handshake with the FPU, presents the result for writeback and owns fflags/frm.
// Optional start-to-done watchdog is enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_op,
    input  logic [2:0]  issue_rm,
    input  logic        issue_rs2_lsb,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic        fpu_rs2_lsb,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [2:0]  fpu_dyn_rm,
    input  logic        fpu_done,
    input  logic [31:0] fpu_out,
    input  logic        fpu_nv,
    input  logic        fpu_dz,
    input  logic        fpu_of,
    input  logic        fpu_uf,
    input  logic        fpu_nx,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    input  logic        csr_we,
    input  logic [4:0]  csr_fflags_wdata,
    input  logic [2:0]  csr_frm_wdata,
    output logic [4:0]  fflags,
    output logic [2:0]  frm,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_WB    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_op;
    logic [2:0]  r_rm;
    logic        r_rs2_lsb;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    logic [31:0] r_res;
    logic [4:0]  r_flags;
    logic [4:0]  r_fflags;
    logic [2:0]  r_frm;

    logic        w_accept;
    logic        w_retire;
    logic        w_capture;
    logic        w_timeout;
    logic        w_running;

    assign w_running = (r_state == S_BUSY) || (r_state == S_DRAIN);
    assign w_accept  = issue_valid && issue_ready;
    assign w_retire  = (r_state == S_WB) && wb_ready && !flush;
    assign w_capture = (r_state == S_BUSY) && !flush && (fpu_done || w_timeout);

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] r_cnt;

    assign w_timeout = w_running && !fpu_done &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_running) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_BUSY;
            end
            S_BUSY: begin
                // A flush coinciding with done/timeout has nothing left to drain.
                if (flush)                       w_next = (fpu_done || w_timeout) ? S_IDLE : S_DRAIN;
                else if (fpu_done || w_timeout)  w_next = S_WB;
            end
            S_WB: begin
                if (flush || wb_ready) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (fpu_done || w_timeout) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_rm      <= '0;
            r_rs2_lsb <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_res     <= '0;
            r_flags   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op      <= issue_op;
                r_rm      <= issue_rm;
                r_rs2_lsb <= issue_rs2_lsb;
                r_a       <= issue_a;
                r_b       <= issue_b;
                r_rd      <= issue_rd;
            end
            if (w_capture) begin
                if (fpu_done) begin
                    r_res   <= fpu_out;
                    r_flags <= {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
                end else begin
                    r_res   <= 32'h7FC0_0000;
                    r_flags <= 5'b10000;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fflags <= '0;
            r_frm    <= '0;
        end else begin
            if (csr_we) begin
                r_frm    <= csr_frm_wdata;
                r_fflags <= csr_fflags_wdata | (w_retire ? r_flags : 5'b00000);
            end else if (w_retire) begin
                r_fflags <= r_fflags | r_flags;
            end
        end
    end

    assign issue_ready = reset && (r_state == S_IDLE) && !flush;
    assign fpu_start   = w_running;
    assign fpu_op      = r_op;
    assign fpu_rm      = r_rm;
    assign fpu_rs2_lsb = r_rs2_lsb;
    assign fpu_a       = r_a;
    assign fpu_b       = r_b;
    assign fpu_dyn_rm  = r_frm;
    assign wb_valid    = (r_state == S_WB);
    assign wb_data     = r_res;
    assign wb_rd       = r_rd;
    assign fflags      = r_fflags;
    assign frm         = r_frm;
    assign timeout_err = w_timeout;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the FPU arithmetic start/done interface; sits between the core's FP execute stage and the FPU arithmetic unit.
- Accepts one FP op from the pipeline (valid/ready), holds operands stable, drives start until done, and captures the result.
- Presents the result on a writeback handshake.
- Owns the fflags/frm CSR state: supplies dynamic rounding mode to the FPU and accumulates sticky exception flags.

Parameters:
- TIMEOUT_CYCLES, 64: watchdog limit on start-to-done cycles; used only when FPU_ISSUE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  pipeline presents an FP op
- issue_ready  out  1  controller can accept an op
- issue_op  in  5  FPU op code
- issue_rm  in  3  instruction rounding field (3'b111 = dynamic)
- issue_rs2_lsb  in  1  signed/unsigned select for conversions
- issue_a, issue_b  in  32  operands
- issue_rd  in  5  destination register tag
- flush  in  1  squash in-flight op
- fpu_start  out  1  start to FPU
- fpu_op  out  5  registered op
- fpu_rm  out  3  registered rm
- fpu_rs2_lsb  out  1  registered rs2_lsb
- fpu_a, fpu_b  out  32  registered operands
- fpu_dyn_rm  out  3  equals frm register
- fpu_done  in  1  FPU done
- fpu_out  in  32  FPU result
- fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx  in  1 each  FPU exception flags
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  32  result
- wb_rd  out  5  destination tag
- csr_we  in  1  CSR write strobe
- csr_fflags_wdata  in  5  new fflags {NV,DZ,OF,UF,NX}
- csr_frm_wdata  in  3  new frm
- fflags  out  5  sticky flags
- frm  out  3  rounding mode register
- timeout_err  out  1  watchdog fired (one-cycle pulse)

Behaviour:
- Reset values: all outputs 0. State is IDLE, fflags=0, frm=0, counter=0.
- States: IDLE, BUSY, WB, DRAIN.
- IDLE:
  - issue_ready=1 unless flush is high.
  - On issue_valid & issue_ready: register op/rm/rs2_lsb/a/b/rd and go to BUSY.
- BUSY:
  - fpu_start=1; operands held constant.
  - When fpu_done=1 is sampled: register fpu_out and the five flags, then go to WB. fpu_start deasserts the following cycle.
  - Single-cycle ops (done is combinational from start) finish in one BUSY cycle.
  - Minimum latency from accept to wb_valid is 2 cycles.
- WB:
  - wb_valid=1; wb_data/wb_rd are stable while wb_ready=0.
  - On wb_ready: OR the captured flags into fflags, then go to IDLE.
  - No new issue is accepted until the cycle after retirement.
- Flush:
  - In BUSY: go to DRAIN. DRAIN keeps fpu_start=1 until fpu_done, then discards result and flags and returns to IDLE.
  - In WB: drop wb_valid with no flag update and go to IDLE.
  - In IDLE: blocks accept for that cycle.
  - In DRAIN: no effect.
- CSR writes:
  - csr_we loads frm = csr_frm_wdata in any state.
  - If a retirement coincides with csr_we: fflags = csr_fflags_wdata | retiring flags.
  - fpu_dyn_rm reflects frm combinationally. An op already in BUSY sees any frm change, because FPU rm resolution is combinational.
- Reset mid-operation: immediately returns to IDLE with fpu_start=0. The FPU's own reset restarts multicycle units.

Optional Feature:
- Macro: FPU_ISSUE_TIMEOUT_EN.
- Defined:
  - A counter increments each BUSY/DRAIN cycle and clears on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES-1 with fpu_done=0: fpu_start drops and timeout_err pulses for 1 cycle.
  - From BUSY: go to WB with wb_data=32'h7FC00000 and captured flags NV=1, others 0.
  - From DRAIN: go to IDLE.
- Undefined: no counter; timeout_err tied 0; waits for done indefinitely.

Test Plan:
- FADD: op=5'b00000, A=32'h3F800000, B=32'h40000000, rm=000, wb_ready=1 -> wb_valid 2 cycles after accept; wb_data=32'h40400000; fflags=5'b00000.
- FDIV by zero: op=5'b00011, A=32'h3F800000, B=32'h00000000 -> fpu_start held through multicycle op; wb_data=32'h7F800000; fflags=5'b01000 after retire.
- Backpressure: wb_ready=0 for 5 cycles after FMUL 2.0*3.0 -> wb_data stable at 32'h40C00000; issue_ready=0 throughout; retire on wb_ready=1.
- Dynamic rm and CSR collision: csr_we with frm=3'b001, then issue rm=3'b111 -> fpu_dyn_rm=3'b001. Then retire an inexact op while csr_we writes fflags=5'b10000 -> fflags=5'b10001.
- Flush: flush during BUSY of an FSQRT -> DRAIN keeps start high until done; no wb_valid; fflags unchanged; next FADD is accepted and completes correctly.
- Timeout (macro on, TIMEOUT_CYCLES=64): stub FPU never asserts done -> timeout_err pulses at 64th BUSY cycle; wb_data=32'h7FC00000; fflags NV set.
